// File: rtl/eth_rx_fifo_pkg.sv
// Shared types and constants for the Ethernet receive frame FIFO.
package eth_rx_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DROP
  } wr_state_e;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

  localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/eth_rx_fifo_ram.sv
// Simple dual-port DEPTH x 9 frame storage, one clock, registered read port.
module eth_rx_fifo_ram
  import eth_rx_fifo_pkg::*;
#(
  parameter  int DEPTH  = 2048,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  fifo_entry_t       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output fifo_entry_t       rdata
);

  fifo_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // rdata holds its value while re is low; the read side uses it as a skid stage
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward receive frame FIFO: bad, oversize and overflowing frames are dropped whole.
// Optional destination-address filter is built when ETH_RX_MAC_FILTER_EN is defined.
module eth_rx_frame_fifo
  import eth_rx_fifo_pkg::*;
#(
  parameter  int DEPTH  = 2048,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      s_axis_tdata,
  input  logic            s_axis_tvalid,
  input  logic            s_axis_tlast,
  input  logic            s_axis_tuser,
  output logic [7:0]      m_axis_tdata,
  output logic            m_axis_tvalid,
  input  logic            m_axis_tready,
  output logic            m_axis_tlast,
  input  logic [47:0]     local_mac,
  output logic            frame_good,
  output logic            drop_bad,
  output logic            drop_overflow,
  output logic            drop_filter,
  output logic [ADDR_W:0] level
);

  localparam logic [ADDR_W:0] DEPTH_PTR = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W + 1)'(1);

  wr_state_e       state_reg, state_next;
  logic [ADDR_W:0] wr_ptr_cur_reg, wr_ptr_cur_next;
  logic [ADDR_W:0] wr_ptr_commit_reg, wr_ptr_commit_next;
  logic [ADDR_W:0] rd_ptr_reg, fetch_ptr_reg, level_reg;
  logic            frame_good_reg, frame_good_next;
  logic            drop_bad_reg, drop_bad_next;
  logic            drop_overflow_reg, drop_overflow_next;
  logic            drop_filter_reg, drop_filter_next;
  logic            full, accept, filter_reject;
  logic            ram_we, ram_re, fetch_avail, out_load;
  logic            ram_valid_reg, m_valid_reg, m_last_reg;
  logic [7:0]      m_data_reg;
  fifo_entry_t     ram_wdata, ram_rdata;

  // rd_ptr only advances on consumption, so prefetched bytes still count as occupied
  assign full      = (wr_ptr_cur_reg - rd_ptr_reg) == DEPTH_PTR;
  assign accept    = s_axis_tvalid && (state_reg != DROP);
  assign ram_wdata = '{last: s_axis_tlast, data: s_axis_tdata};

`ifdef ETH_RX_MAC_FILTER_EN
  logic [2:0] byte_cnt_reg, byte_cnt;
  logic       local_ok_reg, bcast_ok_reg, mcast_reg;
  logic       local_ok, bcast_ok, mcast, in_hdr;
  logic       local_ok_next, bcast_ok_next, mcast_next;
  logic [7:0] local_hit, bcast_hit;

  for (genvar gi = 0; gi < 6; gi++) begin : g_hit
    assign local_hit[gi] = s_axis_tdata == local_mac[47-8*gi -: 8];
    assign bcast_hit[gi] = s_axis_tdata == BROADCAST_MAC[47-8*gi -: 8];
  end
  assign local_hit[7:6] = 2'b00;
  assign bcast_hit[7:6] = 2'b00;

  always_comb begin
    // the first byte of a frame starts from a clean match state
    byte_cnt      = (state_reg == IDLE) ? 3'd0 : byte_cnt_reg;
    local_ok      = (state_reg == IDLE) || local_ok_reg;
    bcast_ok      = (state_reg == IDLE) || bcast_ok_reg;
    mcast         = (state_reg != IDLE) && mcast_reg;
    in_hdr        = byte_cnt < 3'd6;
    local_ok_next = local_ok && (!in_hdr || local_hit[byte_cnt]);
    bcast_ok_next = bcast_ok && (!in_hdr || bcast_hit[byte_cnt]);
    mcast_next    = mcast || ((byte_cnt == 3'd0) && s_axis_tdata[0]);
    filter_reject = in_hdr && !(local_ok_next || bcast_ok_next || mcast_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_reg <= 3'd0;
      local_ok_reg <= 1'b1;
      bcast_ok_reg <= 1'b1;
      mcast_reg    <= 1'b0;
    end else if (accept) begin
      byte_cnt_reg <= in_hdr ? byte_cnt + 3'd1 : byte_cnt;
      local_ok_reg <= local_ok_next;
      bcast_ok_reg <= bcast_ok_next;
      mcast_reg    <= mcast_next;
    end
  end
`else
  logic unused_local_mac;
  assign unused_local_mac = ^local_mac;
  assign filter_reject    = 1'b0;
`endif

  always_comb begin
    state_next         = state_reg;
    wr_ptr_cur_next    = wr_ptr_cur_reg;
    wr_ptr_commit_next = wr_ptr_commit_reg;
    ram_we             = 1'b0;
    frame_good_next    = 1'b0;
    drop_bad_next      = 1'b0;
    drop_overflow_next = 1'b0;
    drop_filter_next   = 1'b0;
    case (state_reg)
      IDLE, WRITE: begin
        if (s_axis_tvalid) begin
          if (s_axis_tlast && s_axis_tuser) begin
            wr_ptr_cur_next = wr_ptr_commit_reg;
            drop_bad_next   = 1'b1;
            state_next      = IDLE;
          end else if (filter_reject) begin
            wr_ptr_cur_next  = wr_ptr_commit_reg;
            drop_filter_next = 1'b1;
            state_next       = s_axis_tlast ? IDLE : DROP;
          end else if (full) begin
            wr_ptr_cur_next    = wr_ptr_commit_reg;
            drop_overflow_next = 1'b1;
            state_next         = s_axis_tlast ? IDLE : DROP;
          end else begin
            ram_we          = 1'b1;
            wr_ptr_cur_next = wr_ptr_cur_reg + PTR_ONE;
            if (s_axis_tlast) begin
              wr_ptr_commit_next = wr_ptr_cur_reg + PTR_ONE;
              frame_good_next    = 1'b1;
              state_next         = IDLE;
            end else begin
              state_next = WRITE;
            end
          end
        end
      end
      DROP: begin
        if (s_axis_tvalid && s_axis_tlast) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      wr_ptr_cur_reg    <= '0;
      wr_ptr_commit_reg <= '0;
      frame_good_reg    <= 1'b0;
      drop_bad_reg      <= 1'b0;
      drop_overflow_reg <= 1'b0;
      drop_filter_reg   <= 1'b0;
    end else begin
      state_reg         <= state_next;
      wr_ptr_cur_reg    <= wr_ptr_cur_next;
      wr_ptr_commit_reg <= wr_ptr_commit_next;
      frame_good_reg    <= frame_good_next;
      drop_bad_reg      <= drop_bad_next;
      drop_overflow_reg <= drop_overflow_next;
      drop_filter_reg   <= drop_filter_next;
    end
  end

  eth_rx_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_cur_reg[ADDR_W-1:0]),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (fetch_ptr_reg[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  // Read pipeline: RAM output register feeds the output register; fetch only when one can move
  assign fetch_avail = fetch_ptr_reg != wr_ptr_commit_reg;
  assign out_load    = ram_valid_reg && (!m_valid_reg || m_axis_tready);
  assign ram_re      = fetch_avail && (!ram_valid_reg || out_load);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_ptr_reg <= '0;
      rd_ptr_reg    <= '0;
      ram_valid_reg <= 1'b0;
      m_valid_reg   <= 1'b0;
      m_data_reg    <= 8'h00;
      m_last_reg    <= 1'b0;
      level_reg     <= '0;
    end else begin
      if (ram_re) fetch_ptr_reg <= fetch_ptr_reg + PTR_ONE;
      ram_valid_reg <= ram_re || (ram_valid_reg && !out_load);
      if (out_load) begin
        m_valid_reg <= 1'b1;
        m_data_reg  <= ram_rdata.data;
        m_last_reg  <= ram_rdata.last;
      end else if (m_axis_tready) begin
        m_valid_reg <= 1'b0;
      end
      if (m_valid_reg && m_axis_tready) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      level_reg <= wr_ptr_commit_reg - rd_ptr_reg;
    end
  end

  assign m_axis_tvalid = m_valid_reg;
  assign m_axis_tdata  = m_data_reg;
  assign m_axis_tlast  = m_last_reg;
  assign frame_good    = frame_good_reg;
  assign drop_bad      = drop_bad_reg;
  assign drop_overflow = drop_overflow_reg;
  assign drop_filter   = drop_filter_reg;
  assign level         = level_reg;

endmodule
